// File: rtl/hop_bench_pkg.sv
// Shared types and defaults for the hop-chain benchmark checker.
//   chk_state_e    : checker FSM states
//   *_DEF          : default lane count, hop latency and counter width
//   sel_width()    : width of a lane select for a given lane count
package hop_bench_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WARM  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } chk_state_e;

    localparam int unsigned NUM_LANES_DEF = 4;
    localparam int unsigned EXP_LAT_DEF   = 3;
    localparam int unsigned CNT_W_DEF     = 16;

    // A single lane still needs a 1-bit select port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hop_lane_checker_if.sv
// Harness <-> checker bus.
//   master : drives arm, clear, start, lane_out, lane_en, lane_sel;
//            observes busy, pass, fail, err_mask, err_cnt, edge_cnt
//   slave  : the checker, opposite directions
interface hop_lane_checker_if
    import hop_bench_pkg::*;
#(
    parameter int unsigned NUM_LANES = NUM_LANES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) ();

    localparam int unsigned SEL_W = sel_width(NUM_LANES);

    logic                 arm;
    logic                 clear;
    logic [NUM_LANES-1:0] start;
    logic [NUM_LANES-1:0] lane_out;
    logic [NUM_LANES-1:0] lane_en;
    logic [SEL_W-1:0]     lane_sel;
    logic                 busy;
    logic                 pass;
    logic                 fail;
    logic [NUM_LANES-1:0] err_mask;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W-1:0]     edge_cnt;

    modport master (
        output arm, clear, start, lane_out, lane_en, lane_sel,
        input  busy, pass, fail, err_mask, err_cnt, edge_cnt
    );

    modport slave (
        input  arm, clear, start, lane_out, lane_en, lane_sel,
        output busy, pass, fail, err_mask, err_cnt, edge_cnt
    );

endinterface

// File: rtl/hop_lane_cmp.sv
// Per-lane checker slice.
//   clock0, rst_n : clock, async active-low reset
//   clr           : arm/clear pulse; zeroes warm count, sticky flag, edge count
//   cmp_en        : checker FSM is in CHECK
//   cnt_en        : checker is busy; edge counting allowed
//   start         : chain stimulus bit
//   lane_out      : chain output bit
//   lane_en       : lane compare enable
//   mis           : combinational mismatch this cycle
//   err_flag      : sticky registered mismatch flag
//   edge_cnt      : saturating count of lane_out rising edges
module hop_lane_cmp
    import hop_bench_pkg::*;
#(
    parameter int unsigned EXP_LAT = EXP_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clock0,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmp_en,
    input  logic             cnt_en,
    input  logic             start,
    input  logic             lane_out,
    input  logic             lane_en,
    output logic             mis,
    output logic             err_flag,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int unsigned WARM_W = $clog2(EXP_LAT + 1);
    localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(EXP_LAT);

    logic [EXP_LAT-1:0] hist_q, hist_d;
    logic [EXP_LAT:0]   hist_ext;
    logic [WARM_W-1:0]  warm_q, warm_d;
    logic               en_prev_q;
    logic               out_prev_q;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   edge_q, edge_d;

    always_ff @(posedge clock0 or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            warm_q     <= '0;
            en_prev_q  <= 1'b0;
            out_prev_q <= 1'b0;
            err_q      <= 1'b0;
            edge_q     <= '0;
        end else begin
            hist_q     <= hist_d;
            warm_q     <= warm_d;
            en_prev_q  <= lane_en;
            out_prev_q <= lane_out;
            err_q      <= err_d;
            edge_q     <= edge_d;
        end
    end

    always_comb begin
        // Shift via a widened vector so EXP_LAT == 1 needs no special case.
        hist_ext = {hist_q, start};
        hist_d   = hist_ext[EXP_LAT-1:0];

        // Disabled, or enabled only this cycle: restart the warm-up.
        if (clr || !lane_en || !en_prev_q) begin
            warm_d = '0;
        end else if (warm_q != WARM_FULL) begin
            warm_d = warm_q + 1'b1;
        end else begin
            warm_d = warm_q;
        end

        mis = cmp_en && lane_en && (warm_q == WARM_FULL) &&
              (lane_out != hist_q[EXP_LAT-1]);

        err_d = clr ? 1'b0 : (err_q | mis);

        if (clr) begin
            edge_d = '0;
        end else if (cnt_en && lane_out && !out_prev_q && (edge_q != '1)) begin
            edge_d = edge_q + 1'b1;
        end else begin
            edge_d = edge_q;
        end
    end

    assign err_flag = err_q;
    assign edge_cnt = edge_q;

endmodule

// File: rtl/hop_lane_checker.sv
// Checks each hop-chain output against its start bit delayed by EXP_LAT clocks.
//   clock0, rst_n : clock, async active-low reset
//   bus (slave)   : arm/clear control, start/lane_out/lane_en per lane, lane_sel;
//                   busy/pass/fail status, err_mask, err_cnt, edge_cnt
module hop_lane_checker
    import hop_bench_pkg::*;
#(
    parameter int unsigned NUM_LANES   = NUM_LANES_DEF,
    parameter int unsigned EXP_LAT     = EXP_LAT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input logic               clock0,
    input logic               rst_n,
    hop_lane_checker_if.slave bus
);

    localparam int unsigned SEL_W  = sel_width(NUM_LANES);
    localparam int unsigned WCNT_W = $clog2(EXP_LAT + 1);

    chk_state_e           state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 clr;
    logic                 cmp_en;
    logic                 cnt_en;
    logic [NUM_LANES-1:0] mis;
    logic [NUM_LANES-1:0] err_flag;
    logic [CNT_W-1:0]     edge_arr [NUM_LANES];

    assign clr    = bus.arm | bus.clear;
    assign cmp_en = (state_q == CHECK);
    assign cnt_en = (state_q != IDLE);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        hop_lane_cmp #(
            .EXP_LAT (EXP_LAT),
            .CNT_W   (CNT_W)
        ) u_cmp (
            .clock0   (clock0),
            .rst_n    (rst_n),
            .clr      (clr),
            .cmp_en   (cmp_en),
            .cnt_en   (cnt_en),
            .start    (bus.start[i]),
            .lane_out (bus.lane_out[i]),
            .lane_en  (bus.lane_en[i]),
            .mis      (mis[i]),
            .err_flag (err_flag[i]),
            .edge_cnt (edge_arr[i])
        );
    end

    // State register
    always_ff @(posedge clock0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.arm) begin
            state_d = WARM;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                WARM:    if (wcnt_q == WCNT_W'(EXP_LAT - 1)) state_d = CHECK;
                CHECK:   if (STOP_ON_ERR && (|mis)) state_d = FAIL;
                FAIL:    state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end

        // WARM lasts exactly EXP_LAT clocks.
        wcnt_d = (state_q == WARM && !clr) ? wcnt_q + 1'b1 : '0;

        // Add one per mismatching lane, saturating at all-ones.
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mis[i] && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.busy     = (state_q != IDLE);
        bus.pass     = (state_q == CHECK) && (err_cnt_q == '0);
        bus.fail     = (state_q == FAIL) || (!STOP_ON_ERR && (err_cnt_q != '0));
        bus.err_mask = err_flag;
        bus.err_cnt  = err_cnt_q;
        // Unmatched select values (non power-of-two lane counts) read as zero.
        bus.edge_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.lane_sel == SEL_W'(i)) bus.edge_cnt = edge_arr[i];
        end
    end

endmodule

// File: tb/tb_hop_lane_checker.sv
module tb_hop_lane_checker;

    logic clock0;
    logic rst_n;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    hop_lane_checker_if #(.NUM_LANES(4), .CNT_W(16)) bus ();
    hop_lane_checker_if #(.NUM_LANES(4), .CNT_W(4))  bus6 ();

    hop_lane_checker #(
        .NUM_LANES   (4),
        .EXP_LAT     (3),
        .CNT_W       (16),
        .STOP_ON_ERR (1'b1)
    ) dut (
        .clock0 (clock0),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    hop_lane_checker #(
        .NUM_LANES   (4),
        .EXP_LAT     (3),
        .CNT_W       (4),
        .STOP_ON_ERR (1'b0)
    ) dut6 (
        .clock0 (clock0),
        .rst_n  (rst_n),
        .bus    (bus6.slave)
    );

    // Three-hop chain model feeding lane_out, with per-bit override for fault injection.
    logic [3:0] ff_a, ff_b, ff_c, keep;
    logic [3:0] ovr_mask, ovr_val, ovr6;
    logic       chain_rst1;

    assign keep = chain_rst1 ? 4'b1101 : 4'b1111;

    always_ff @(posedge clock0 or negedge rst_n) begin
        if (!rst_n) begin
            ff_a <= '0;
            ff_b <= '0;
            ff_c <= '0;
        end else begin
            ff_a <= bus.start & keep;
            ff_b <= ff_a & keep;
            ff_c <= ff_b & keep;
        end
    end

    assign bus.lane_out  = (ff_c & ~ovr_mask) | (ovr_val & ovr_mask);
    assign bus6.lane_out = ovr6;

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock0);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.arm       = 1'b0;
        bus.clear     = 1'b0;
        bus.start     = '0;
        bus.lane_en   = 4'hF;
        bus.lane_sel  = '0;
        bus6.arm      = 1'b0;
        bus6.clear    = 1'b0;
        bus6.start    = '0;
        bus6.lane_en  = 4'hF;
        bus6.lane_sel = '0;
        ovr_mask      = '0;
        ovr_val       = '0;
        ovr6          = '0;
        chain_rst1    = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pass", 32'(bus.pass), 0);
        chk("rst_fail", 32'(bus.fail), 0);
        chk("rst_mask", 32'(bus.err_mask), 0);
        chk("rst_errcnt", 32'(bus.err_cnt), 0);
        chk("rst_edgecnt", 32'(bus.edge_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Single pulse on lane 0 through the real chain.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("warm_busy", 32'(bus.busy), 1);
        bus.start = 4'b0001;
        tick();
        bus.start = 4'b0000;
        tick();
        chk("warm_nopass", 32'(bus.pass), 0);
        tick();
        chk("check_pass", 32'(bus.pass), 1);
        chk("edge_before", 32'(bus.edge_cnt), 0);
        tick();
        chk("edge_lane0", 32'(bus.edge_cnt), 1);
        chk("pass_lane0", 32'(bus.pass), 1);
        chk("errcnt_lane0", 32'(bus.err_cnt), 0);

        // Lane 2 output forced high one cycle before the real pulse arrives.
        bus.start = 4'b0100;
        tick();
        bus.start = 4'b0000;
        tick();
        ovr_mask = 4'b0100;
        ovr_val  = 4'b0100;
        tick();
        chk("early_mask", 32'(bus.err_mask), 32'h4);
        chk("early_errcnt", 32'(bus.err_cnt), 1);
        chk("early_fail", 32'(bus.fail), 1);
        chk("early_pass", 32'(bus.pass), 0);
        // In FAIL: a bogus lane-3 pulse is counted as an edge, not an error.
        ovr_mask = 4'b1000;
        ovr_val  = 4'b1000;
        tick();
        ovr_mask     = '0;
        ovr_val      = '0;
        bus.lane_sel = 2'd3;
        tick();
        chk("fail_errcnt", 32'(bus.err_cnt), 1);
        chk("fail_mask", 32'(bus.err_mask), 32'h4);
        chk("fail_edge3", 32'(bus.edge_cnt), 1);
        bus.lane_sel = 2'd2;
        #1;
        chk("fail_edge2", 32'(bus.edge_cnt), 1);

        // Lane 1 disabled during its chain reset, then warm-up after re-enable.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("rearm_mask", 32'(bus.err_mask), 0);
        chk("rearm_errcnt", 32'(bus.err_cnt), 0);
        chk("rearm_fail", 32'(bus.fail), 0);
        tick(3);
        chk("rearm_pass", 32'(bus.pass), 1);
        bus.lane_en = 4'b1101;
        ovr_mask    = 4'b0010;
        ovr_val     = 4'b0010;
        chain_rst1  = 1'b1;
        tick();
        chain_rst1 = 1'b0;
        tick();
        chk("dis_errcnt", 32'(bus.err_cnt), 0);
        chk("dis_mask", 32'(bus.err_mask), 0);
        bus.lane_en = 4'b1111;
        tick(4);
        chk("warmup_errcnt", 32'(bus.err_cnt), 0);
        chk("warmup_pass", 32'(bus.pass), 1);
        tick();
        chk("resume_mask", 32'(bus.err_mask), 32'h2);
        chk("resume_errcnt", 32'(bus.err_cnt), 1);
        chk("resume_fail", 32'(bus.fail), 1);
        ovr_mask = '0;
        ovr_val  = '0;

        // arm and clear together in CHECK: clear wins.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick(3);
        bus.lane_sel = 2'd0;
        bus.start    = 4'b0001;
        tick();
        bus.start = 4'b0000;
        tick(3);
        chk("pre_clr_edge", 32'(bus.edge_cnt), 1);
        chk("pre_clr_pass", 32'(bus.pass), 1);
        bus.arm   = 1'b1;
        bus.clear = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.clear = 1'b0;
        chk("clr_busy", 32'(bus.busy), 0);
        chk("clr_pass", 32'(bus.pass), 0);
        chk("clr_edge", 32'(bus.edge_cnt), 0);
        chk("clr_errcnt", 32'(bus.err_cnt), 0);
        tick();
        chk("clr_stay_idle", 32'(bus.busy), 0);

        // Narrow counter, no stop on error: saturation at 15.
        bus6.arm = 1'b1;
        tick();
        bus6.arm = 1'b0;
        tick(3);
        chk("sat_pass0", 32'(bus6.pass), 1);
        ovr6 = 4'b0001;
        tick();
        chk("sat_cnt1", 32'(bus6.err_cnt), 1);
        chk("sat_fail", 32'(bus6.fail), 1);
        chk("sat_busy", 32'(bus6.busy), 1);
        tick(13);
        chk("sat_cnt14", 32'(bus6.err_cnt), 14);
        tick(6);
        chk("sat_cnt15", 32'(bus6.err_cnt), 15);
        ovr6 = '0;

        // Asynchronous reset in the middle of CHECK.
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        tick(3);
        chk("pre_rst_pass", 32'(bus.pass), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_pass", 32'(bus.pass), 0);
        chk("arst6_errcnt", 32'(bus6.err_cnt), 0);
        chk("arst6_fail", 32'(bus6.fail), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst6_busy", 32'(bus6.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
